// File: rtl/cordic_phase_ctrl_if.sv
// Host-side bus of the CORDIC phase controller.
// Carries sample handshake, clear request and the result/timeout strobes.
interface cordic_phase_ctrl_if;
  logic               i_valid;
  logic               o_ready;
  logic signed [3:0]  i_I;
  logic signed [3:0]  i_Q;
  logic               i_clear;
  logic               o_valid;
  logic signed [15:0] o_angle;
  logic signed [15:0] o_delta;
  logic               o_dir;
  logic               o_timeout;

  // Controller side
  modport slave (
    input  i_valid, i_I, i_Q, i_clear,
    output o_ready, o_valid, o_angle, o_delta, o_dir, o_timeout
  );

  // Host / sample source side
  modport master (
    output i_valid, i_I, i_Q, i_clear,
    input  o_ready, o_valid, o_angle, o_delta, o_dir, o_timeout
  );
endinterface

// File: rtl/cordic_phase_ctrl.sv
// CORDIC phase controller: launches one I/Q sample at a time into an
// external CORDIC engine, waits (bounded) for its angle, and reports the
// angle together with the wrapped phase step from the previous angle.
module cordic_phase_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  cordic_phase_ctrl_if.slave bus,
  output logic               o_cordic_start,
  output logic signed [3:0]  o_cordic_I,
  output logic signed [3:0]  o_cordic_Q,
  input  logic               i_cordic_done,
  input  logic signed [15:0] i_cordic_angle
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_DIFF, S_OUT
  } state_t;

  localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [7:0]         r_wait_cnt;
  logic signed [3:0]  r_op_I;
  logic signed [3:0]  r_op_Q;
  logic signed [15:0] r_angle;
  logic signed [15:0] r_prev_angle;
  logic               r_have_prev;
  logic signed [15:0] r_out_angle;
  logic signed [15:0] r_out_delta;
  logic               r_out_dir;
  logic signed [16:0] w_delta_raw;
  logic signed [16:0] w_delta_wrap;
  logic signed [15:0] w_delta;

  assign o_cordic_I    = r_op_I;
  assign o_cordic_Q    = r_op_Q;
  assign bus.o_angle   = r_out_angle;
  assign bus.o_delta   = r_out_delta;
  assign bus.o_dir     = r_out_dir;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-state strobes; done beats timeout in the last WAIT cycle
  always_comb begin
    w_state_next   = r_state;
    o_cordic_start = 1'b0;
    bus.o_ready    = 1'b0;
    bus.o_valid    = 1'b0;
    bus.o_timeout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.o_ready = 1'b1;
        if (bus.i_valid) w_state_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        o_cordic_start = 1'b1;
        w_state_next   = S_WAIT;
      end
      S_WAIT: begin
        if (i_cordic_done) begin
          w_state_next = S_DIFF;
        end else if (r_wait_cnt == LP_WAIT_LAST) begin
          bus.o_timeout = 1'b1;
          w_state_next  = S_IDLE;
        end
      end
      S_DIFF: w_state_next = S_OUT;
      S_OUT: begin
        bus.o_valid  = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Phase step wrapped into -179..180; zero when no reference angle exists
  always_comb begin
    w_delta_raw  = {r_angle[15], r_angle} - {r_prev_angle[15], r_prev_angle};
    w_delta_wrap = w_delta_raw;
    if (w_delta_raw > 17'sd180) begin
      w_delta_wrap = w_delta_raw - 17'sd360;
    end else if (w_delta_raw <= -17'sd180) begin
      w_delta_wrap = w_delta_raw + 17'sd360;
    end
    w_delta = '0;
    if (r_have_prev && !bus.i_clear) w_delta = w_delta_wrap[15:0];
  end

  // Operand capture, wait counting, angle capture and result registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wait_cnt   <= '0;
      r_op_I       <= '0;
      r_op_Q       <= '0;
      r_angle      <= '0;
      r_prev_angle <= '0;
      r_have_prev  <= 1'b0;
      r_out_angle  <= '0;
      r_out_delta  <= '0;
      r_out_dir    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_valid) begin
            r_op_I <= bus.i_I;
            r_op_Q <= bus.i_Q;
          end
        end
        S_LAUNCH: r_wait_cnt <= '0;
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 8'd1;
          if (i_cordic_done) r_angle <= i_cordic_angle;
        end
        S_DIFF: begin
          r_out_angle  <= r_angle;
          r_out_delta  <= w_delta;
          r_out_dir    <= (w_delta > 16'sd0);
          r_prev_angle <= r_angle;
        end
        default: ;
      endcase
      // A clear in DIFF only zeroes this delta; the new angle becomes the reference
      if (r_state == S_DIFF) begin
        r_have_prev <= 1'b1;
      end else if (bus.i_clear) begin
        r_have_prev <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cordic_phase_ctrl.sv
// Self-checking bench for cordic_phase_ctrl: directed cases plus random
// transactions checked against a simple phase-tracking model.
module tb_cordic_phase_ctrl;
  localparam int TIMEOUT = 16;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               cordic_start;
  logic signed [3:0]  cordic_I;
  logic signed [3:0]  cordic_Q;
  logic               cordic_done = 1'b0;
  logic signed [15:0] cordic_angle = '0;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit have_prev = 0;
  int prev_angle = 0;
  int exp_angle = 0, exp_delta = 0, exp_dir = 0;

  cordic_phase_ctrl_if bus ();

  cordic_phase_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus.slave),
    .o_cordic_start (cordic_start),
    .o_cordic_I     (cordic_I),
    .o_cordic_Q     (cordic_Q),
    .i_cordic_done  (cordic_done),
    .i_cordic_angle (cordic_angle)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Phase step by modular arithmetic: result in -179..180
  function automatic int ref_delta(input int prev, input int cur);
    int d;
    d = (cur - prev) % 360;
    if (d < 0) d += 360;
    if (d > 180) d -= 360;
    return d;
  endfunction

  task automatic check_held();
    check_eq("angle_held", int'(bus.o_angle), exp_angle);
    check_eq("delta_held", int'(bus.o_delta), exp_delta);
    check_eq("dir_held", int'(bus.o_dir), exp_dir);
  endtask

  // One sample: accept, launch, wait `delay` empty WAIT cycles, then done.
  task automatic run_txn(input int ii, input int qq, input int angle, input int delay,
                         input bit clr_diff, input bit hold_valid);
    logic signed [3:0] vi, vq;
    bit done_seen;
    int got_d;
    vi = 4'(ii);
    vq = 4'(qq);
    @(negedge clock);
    bus.i_clear = 0; bus.i_valid = 1; bus.i_I = vi; bus.i_Q = vq; #1;
    check_eq("ready_idle", int'(bus.o_ready), 1);
    @(negedge clock);
    bus.i_valid = hold_valid;
    if (hold_valid) begin bus.i_I = ~vi; bus.i_Q = ~vq; end
    #1;
    check_eq("start_launch", int'(cordic_start), 1);
    check_eq("ready_launch", int'(bus.o_ready), 0);
    check_eq("opI_launch", int'(cordic_I), int'(vi));
    check_eq("opQ_launch", int'(cordic_Q), int'(vq));
    done_seen = 0;
    for (int w = 0; w < TIMEOUT; w++) begin
      @(negedge clock);
      cordic_done = (w == delay); cordic_angle = 16'(angle); #1;
      check_eq("start_wait", int'(cordic_start), 0);
      check_eq("ready_wait", int'(bus.o_ready), 0);
      check_eq("valid_wait", int'(bus.o_valid), 0);
      check_eq("opI_wait", int'(cordic_I), int'(vi));
      check_eq("opQ_wait", int'(cordic_Q), int'(vq));
      check_eq("timeout_wait", int'(bus.o_timeout), (w == TIMEOUT-1 && w != delay) ? 1 : 0);
      if (w == delay) begin done_seen = 1; break; end
    end
    if (!done_seen) begin
      @(negedge clock);
      cordic_done = 0; bus.i_valid = 0; #1;
      check_eq("ready_after_to", int'(bus.o_ready), 1);
      check_eq("timeout_once", int'(bus.o_timeout), 0);
      check_eq("valid_after_to", int'(bus.o_valid), 0);
      check_held();
      $display("[TB] txn I=%0d Q=%0d angle=%0d -> timeout", ii, qq, angle);
      return;
    end
    @(negedge clock);
    cordic_done = 0; bus.i_clear = clr_diff; #1;
    check_eq("valid_diff", int'(bus.o_valid), 0);
    check_eq("ready_diff", int'(bus.o_ready), 0);
    exp_delta = (have_prev && !clr_diff) ? ref_delta(prev_angle, angle) : 0;
    exp_angle = angle;
    exp_dir = (exp_delta > 0) ? 1 : 0;
    prev_angle = angle;
    have_prev = 1;
    @(negedge clock);
    bus.i_clear = 0; bus.i_valid = 0; #1;
    check_eq("valid_out", int'(bus.o_valid), 1);
    got_d = int'(bus.o_delta);
    check_held();
    @(negedge clock);
    #1;
    check_eq("valid_once", int'(bus.o_valid), 0);
    check_eq("ready_back", int'(bus.o_ready), 1);
    check_held();
    $display("[TB] txn I=%0d Q=%0d angle=%0d clr=%0d -> delta=%0d exp=%0d",
             ii, qq, angle, clr_diff, got_d, exp_delta);
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1;
    repeat (2) @(negedge clock);
    reset = 0;
    have_prev = 0; exp_angle = 0; exp_delta = 0; exp_dir = 0;
    #1;
    check_eq("ready_after_rst", int'(bus.o_ready), 1);
    check_eq("start_rst", int'(cordic_start), 0);
    check_eq("valid_rst", int'(bus.o_valid), 0);
    check_eq("timeout_rst", int'(bus.o_timeout), 0);
    check_eq("opI_rst", int'(cordic_I), 0);
    check_eq("opQ_rst", int'(cordic_Q), 0);
    check_held();
    $display("[TB] reset applied");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ang, dly, ng;
    bit clr;
    bus.i_valid = 0; bus.i_I = 0; bus.i_Q = 0; bus.i_clear = 0;
    do_reset();

    run_txn(3, 3, 45, 5, 0, 0);          // first sample: delta 0
    run_txn(1, 2, 90, 0, 0, 0);          // +45
    run_txn(2, 1, 60, 2, 0, 0);          // -30
    run_txn(1, 1, 170, 1, 0, 0);
    run_txn(-1, 1, -170, 1, 0, 0);       // +20 across the wrap
    run_txn(-1, -1, 170, 3, 0, 0);       // -20 across the wrap
    run_txn(2, 0, 0, 0, 0, 0);
    run_txn(-8, 0, 180, 0, 0, 0);        // exactly +180
    run_txn(5, 5, 77, 255, 0, 0);        // done never comes
    run_txn(3, 3, 45, 0, 0, 0);          // reference kept across timeout: -135
    run_txn(4, 4, 90, 1, 1, 0);          // clear in DIFF: delta 0
    run_txn(4, 5, 100, 0, 0, 0);         // +10
    run_txn(7, -8, 0, TIMEOUT-1, 0, 0);  // done in the timeout cycle wins
    run_txn(-3, 6, 30, 4, 0, 1);         // valid held high while busy

    // reset during WAIT, then a stray done
    @(negedge clock); bus.i_valid = 1; bus.i_I = 4'sd5; bus.i_Q = 4'sd6;
    @(negedge clock); bus.i_valid = 0;
    repeat (2) @(negedge clock);
    do_reset();
    @(negedge clock); cordic_done = 1; cordic_angle = 16'sd33; #1;
    check_eq("valid_stray", int'(bus.o_valid), 0);
    @(negedge clock); cordic_done = 0;
    repeat (3) begin
      @(negedge clock); #1;
      check_eq("valid_after_stray", int'(bus.o_valid), 0);
      check_eq("ready_after_stray", int'(bus.o_ready), 1);
      check_held();
    end
    run_txn(1, 1, 120, 2, 0, 0);         // first after reset: delta 0

    // random transactions with random idle-time clears
    for (int n = 0; n < 60; n++) begin
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        @(negedge clock);
        bus.i_clear = ($urandom_range(0, 3) == 0);
        if (bus.i_clear) have_prev = 0;
        #1;
        check_eq("ready_gap", int'(bus.o_ready), 1);
      end
      ang = int'($urandom_range(0, 360)) - 180;
      dly = int'($urandom_range(0, 20));
      clr = ($urandom_range(0, 7) == 0);
      run_txn(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), ang, dly, clr,
              $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cordic_phase_ctrl.md
CORDIC_PHASE_CTRL -- requirements
Module: cordic_phase_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 16, maximum WAIT cycles for i_cordic_done before abort (legal range 2..255).
REQ-002 Port: clock  input  1  system clock, all state on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: i_valid  input  1  upstream I/Q sample valid.
REQ-005 Port: o_ready  output  1  block can accept a sample.
REQ-006 Port: i_I, i_Q  input  4 each  signed two's-complement I/Q sample.
REQ-007 Port: i_clear  input  1  synchronous; forget the previous angle.
REQ-008 Port: o_cordic_start  output  1  one-cycle launch pulse to the CORDIC engine.
REQ-009 Port: o_cordic_I, o_cordic_Q  output  4 each  operands to the CORDIC engine.
REQ-010 Port: i_cordic_done  input  1  CORDIC result valid, one-cycle pulse.
REQ-011 Port: i_cordic_angle  input  16  signed angle in degrees, range -180..180.
REQ-012 Port: o_valid  output  1  one-cycle result strobe.
REQ-013 Port: o_angle, o_delta  output  16 each  signed current angle; wrapped phase difference.
REQ-014 Port: o_dir  output  1  1 when o_delta > 0, else 0.
REQ-015 Port: o_timeout  output  1  one-cycle pulse on CORDIC abort.

Function
REQ-016 The FSM SHALL have states IDLE, LAUNCH, WAIT, DIFF, OUT.
REQ-017 IDLE: o_ready=1; on i_valid=1, capture i_I/i_Q into operand registers and go to LAUNCH. o_ready SHALL be 0 in every other state.
REQ-018 LAUNCH: o_cordic_start=1 for exactly this one cycle; go to WAIT; wait counter cleared.
REQ-019 o_cordic_I/o_cordic_Q SHALL be driven from the operand registers and SHALL stay stable from LAUNCH until the FSM leaves WAIT.
REQ-020 WAIT: on i_cordic_done=1, register i_cordic_angle and go to DIFF. i_cordic_done is ignored in every other state.
REQ-021 WAIT: if TIMEOUT cycles elapse in WAIT with no done, pulse o_timeout for one cycle and return to IDLE. No o_valid. Previous angle and first-sample flag unchanged.
REQ-022 DIFF: delta = angle - prev_angle computed at 17 bits signed. If delta > 180, subtract 360. If delta <= -180, add 360. Result range -179..180, truncated to 16 bits.
REQ-023 DIFF: if no previous angle is held (first sample after reset or clear), delta SHALL be 0.
REQ-024 DIFF: prev_angle <= angle; set the previous-held flag; go to OUT.
REQ-025 OUT: o_valid=1 for one cycle; go to IDLE. o_angle, o_delta and o_dir are registered and SHALL hold their values until the next OUT.
REQ-026 Latency: sample accepted at edge k gives start high in cycle k+1. Done seen in cycle d gives o_valid high in cycle d+2.
REQ-027 Throughput: at most one sample in flight. Minimum spacing between acceptances is 5 cycles (done in the first WAIT cycle).
REQ-028 i_clear clears the previous-held flag in any state. If i_clear=1 in DIFF, the current sample SHALL be treated as a first sample (delta=0), and its angle still becomes prev_angle.
REQ-029 An i_cordic_done coincident with the timeout cycle SHALL be accepted (done has priority over timeout).

Reset
REQ-030 On reset: state=IDLE; o_cordic_start=0, o_valid=0, o_timeout=0, o_angle=0, o_delta=0, o_dir=0, o_cordic_I=0, o_cordic_Q=0; previous-held flag cleared; wait counter=0.
REQ-031 Reset asserted mid-operation (LAUNCH/WAIT/DIFF/OUT) SHALL abort with no o_valid. A later done pulse SHALL be ignored until a new LAUNCH.
REQ-032 o_ready SHALL be 1 in the first cycle after reset deassertion.

Verification
REQ-033 Reset, send I=3,Q=3, done after 6 cycles with angle=45 -> o_valid once, o_angle=45, o_delta=0, o_dir=0; start pulse exactly 1 cycle.
REQ-034 After REQ-033, send a sample, CORDIC returns 90 -> o_delta=45, o_dir=1; next returns 60 -> o_delta=-30, o_dir=0.
REQ-035 Wrap: prev=170, new=-170 -> o_delta=20, o_dir=1; prev=-170, new=170 -> o_delta=-20, o_dir=0; prev=0, new=180 -> o_delta=180.
REQ-036 Timeout: with TIMEOUT=16, done never comes -> o_timeout pulses in the 16th WAIT cycle, no o_valid, o_ready=1 next cycle; prev angle preserved across timeout.
REQ-037 i_clear asserted in DIFF with prev=45, new=90 -> o_delta=0; the following sample with angle=100 -> o_delta=10.
REQ-038 Reset asserted in WAIT, then a stray done -> no o_valid; i_valid held high during busy states -> no second capture until IDLE, operands stable throughout.
